// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution engine's output stage.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} z_str_state_t;

  // Length of the full linear convolution of a size_y vector with size_h taps.
  function automatic int z_len(input int size_y, input int size_h);
    return size_y + size_h - 1;
  endfunction

endpackage

// File: rtl/conv_z_skid_fifo.sv
// Two-entry synchronous FIFO. Accepts a push into a full FIFO when a pop happens
// in the same cycle, so a steady one-word-per-cycle stream never stalls.
module conv_z_skid_fifo #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (count_reg != 2'd0);
  assign do_push = push && ((count_reg != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) slot_reg[i] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) begin
        slot_reg[wr_ptr_reg] <= din;
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (do_pop) rd_ptr_reg <= ~rd_ptr_reg;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = slot_reg[rd_ptr_reg];
  assign full  = (count_reg == 2'd2);
  assign empty = (count_reg == 2'd0);
  assign count = count_reg;

endmodule

// File: rtl/conv_z_streamer.sv
// Streams result memory Z out on a valid/ready port after the convolution engine
// finishes, hiding the one-cycle MEM_Z read latency behind a two-entry FIFO.
module conv_z_streamer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH_OUT  = 16,
  parameter int ADDRESS_WIDTH   = 5,
  parameter int ADDRESS_WIDTH_Z = 6,
  parameter int SIZE_H          = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       done_i,
  input  logic [ADDRESS_WIDTH-1:0]   size_y_i,
  output logic [ADDRESS_WIDTH_Z-1:0] mem_z_addr_o,
  input  logic [DATA_WIDTH_OUT-1:0]  mem_z_data_i,
  output logic [DATA_WIDTH_OUT-1:0]  m_data_o,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic                       m_last_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       overrun_o
);

  if (2**ADDRESS_WIDTH - 1 + SIZE_H - 1 > 2**ADDRESS_WIDTH_Z) begin : g_bad_cfg
    $error("conv_z_streamer: ADDRESS_WIDTH_Z too small for the longest Z vector");
  end

  z_str_state_t               state_reg;
  logic [ADDRESS_WIDTH_Z-1:0] rd_addr_reg;
  logic [ADDRESS_WIDTH_Z-1:0] last_addr_reg;
  logic                       inflight_reg;
  logic                       inflight_last_reg;
  logic                       done_reg;
  logic                       overrun_reg;

  logic [DATA_WIDTH_OUT:0]    fifo_din;
  logic [DATA_WIDTH_OUT:0]    fifo_dout;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [1:0]                 fifo_count;
  logic                       pop;
  logic                       issue;
  logic                       at_last_addr;
  logic [ADDRESS_WIDTH_Z-1:0] last_addr_next;

  assign last_addr_next = ADDRESS_WIDTH_Z'(z_len(int'(size_y_i), SIZE_H) - 1);
  assign at_last_addr   = (rd_addr_reg == last_addr_reg);
  assign pop            = m_valid_o && m_ready_i;

  // A slot freed by this cycle's transfer counts as free; without that credit the
  // three-cycle issue-to-pop loop would only sustain two words every three cycles.
  assign issue = (state_reg == READ) && !(fifo_full && !pop) &&
                 (({1'b0, fifo_count} + {2'b00, inflight_reg}) < ({2'b00, pop} + 3'd2));

  assign fifo_din = {inflight_last_reg, mem_z_data_i};

  conv_z_skid_fifo #(
    .WIDTH (DATA_WIDTH_OUT + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_reg),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      rd_addr_reg       <= '0;
      last_addr_reg     <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      done_reg          <= 1'b0;
      overrun_reg       <= 1'b0;
    end else begin
      done_reg          <= 1'b0;
      inflight_reg      <= issue;
      inflight_last_reg <= issue && at_last_addr;
      if (done_i && busy_o) overrun_reg <= 1'b1;
      case (state_reg)
        IDLE, FIN: begin
          state_reg <= IDLE;
          if (done_i) begin
            rd_addr_reg   <= '0;
            last_addr_reg <= last_addr_next;
            if (size_y_i == '0) begin
              state_reg <= FIN;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= READ;
            end
          end
        end
        READ: begin
          // The address holds at the final element so the read port never leaves 0..Nz-1.
          if (issue) begin
            if (at_last_addr) state_reg <= DRAIN;
            else              rd_addr_reg <= rd_addr_reg + 1'b1;
          end
        end
        DRAIN: begin
          if (pop && m_last_o) begin
            state_reg <= FIN;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_z_addr_o = rd_addr_reg;
  assign m_valid_o    = !fifo_empty;
  assign m_data_o     = fifo_dout[DATA_WIDTH_OUT-1:0];
  assign m_last_o     = m_valid_o && fifo_dout[DATA_WIDTH_OUT];
  assign busy_o       = (state_reg == READ) || (state_reg == DRAIN);
  assign done_o       = done_reg;
  assign overrun_o    = overrun_reg;

endmodule

// File: tb/tb_conv_z_streamer.sv
// Randomized bench for conv_z_streamer: a registered-read MEM_Z model feeds the DUT and
// every job's output stream is scored against the words the bench wrote into memory.
module tb_conv_z_streamer;

  localparam int DW  = 16;
  localparam int AW  = 5;
  localparam int AWZ = 6;
  localparam int SH  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           done_i;
  logic [AW-1:0]  size_y_i;
  logic [AWZ-1:0] mem_z_addr_o;
  logic [DW-1:0]  mem_z_data_i;
  logic [DW-1:0]  m_data_o;
  logic           m_valid_o;
  logic           m_ready_i;
  logic           m_last_o;
  logic           busy_o;
  logic           done_o;
  logic           overrun_o;

  logic [DW-1:0]  mem_z [64];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_z_data_i <= mem_z[mem_z_addr_o];

  conv_z_streamer #(
    .DATA_WIDTH_OUT  (DW),
    .ADDRESS_WIDTH   (AW),
    .ADDRESS_WIDTH_Z (AWZ),
    .SIZE_H          (SH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .done_i       (done_i),
    .size_y_i     (size_y_i),
    .mem_z_addr_o (mem_z_addr_o),
    .mem_z_data_i (mem_z_data_i),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_last_o     (m_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .overrun_o    (overrun_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"},   32'(m_valid_o), 0);
    check({tag, "_data"},    32'(m_data_o), 0);
    check({tag, "_last"},    32'(m_last_o), 0);
    check({tag, "_busy"},    32'(busy_o), 0);
    check({tag, "_done"},    32'(done_o), 0);
    check({tag, "_overrun"}, 32'(overrun_o), 0);
    check({tag, "_addr"},    32'(mem_z_addr_o), 0);
  endtask

  // mode 0: ready always high, 1: ready alternates 1,0,..., 2: random ready.
  // ovr_at != 0 pulses a second done_i that many cycles into the job.
  task automatic run_job(input int size, input int mode, input int ovr_at);
    logic [DW-1:0] exp_q [$];
    int nz, idx, rel, done_rel, first_rel, last_rel, max_addr;
    bit done_seen, rdy, prev_stall, prev_last;
    logic [DW-1:0] prev_data;

    nz = (size == 0) ? 0 : size + SH - 1;
    for (int i = 0; i < 64; i++) mem_z[i] = DW'($urandom);
    for (int i = 0; i < nz; i++) exp_q.push_back(mem_z[i]);

    done_i   = 1'b1;
    size_y_i = AW'(size);
    step();
    done_i   = 1'b0;
    size_y_i = AW'($urandom);

    idx = 0; rel = 1; done_rel = -1; first_rel = -1; last_rel = -1; max_addr = 0;
    done_seen = 0; prev_stall = 0; prev_last = 0; prev_data = '0;
    while (!done_seen && rel < 600) begin
      done_i = (ovr_at != 0 && rel == ovr_at);
      if (done_i) size_y_i = AW'(7);
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid_o), 1);
        check("stall_data",  32'(m_data_o), 32'(prev_data));
        check("stall_last",  32'(m_last_o), 32'(prev_last));
      end
      if (m_valid_o && first_rel < 0) first_rel = rel;
      if (busy_o && int'(mem_z_addr_o) > max_addr) max_addr = int'(mem_z_addr_o);
      if (done_o) begin
        done_seen = 1;
        done_rel  = rel;
        check("busy_at_done",  32'(busy_o), 0);
        check("valid_at_done", 32'(m_valid_o), 0);
      end else begin
        check("busy_in_job", 32'(busy_o), 1);
        rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (rel % 2 == 1) : ($urandom_range(0, 2) != 0);
        m_ready_i = rdy;
        if (m_valid_o && rdy) begin
          if (idx < nz) begin
            check("data", 32'(m_data_o), 32'(exp_q[idx]));
            check("last", 32'(m_last_o), 32'(idx == nz - 1));
          end else begin
            check("extra_word", idx, nz);
          end
          idx++;
          last_rel = rel;
        end
        prev_stall = m_valid_o && !rdy;
        prev_data  = m_data_o;
        prev_last  = m_last_o;
        step();
        rel++;
      end
    end
    done_i = 1'b0;

    check("done_seen", 32'(done_seen), 1);
    check("word_count", idx, nz);
    if (nz == 0) begin
      check("empty_no_valid", first_rel, -1);
      check("empty_done_cycle", done_rel, 1);
    end else begin
      check("addr_in_range", 32'(max_addr <= nz - 1), 1);
      if (mode == 0) begin
        check("first_valid_cycle", first_rel, 3);
        check("last_xfer_cycle", last_rel, 2 + nz);
        check("done_cycle", done_rel, 3 + nz);
      end
    end
    if (ovr_at != 0) check("overrun_sticky", 32'(overrun_o), 1);
    $display("job size=%0d nz=%0d mode=%0d words=%0d done_rel=%0d overrun=%0b",
             size, nz, mode, idx, done_rel, overrun_o);
  endtask

  // Abort a size_y=2 job after two transfers and confirm the block comes back clean.
  task automatic reset_abort_job();
    int xfers, rel;
    bit spurious;
    for (int i = 0; i < 64; i++) mem_z[i] = DW'($urandom);
    done_i    = 1'b1;
    size_y_i  = AW'(2);
    m_ready_i = 1'b1;
    step();
    done_i = 1'b0;
    xfers = 0;
    rel   = 1;
    while (xfers < 2 && rel < 50) begin
      if (m_valid_o) xfers++;
      step();
      rel++;
    end
    check("abort_xfers", xfers, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_outputs("after_abort");
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done_o || m_valid_o || busy_o) spurious = 1;
    end
    check("aborted_job_silent", 32'(spurious), 0);
    $display("job aborted by reset after %0d transfers", xfers);
  endtask

  initial begin
    rst       = 1'b1;
    done_i    = 1'b0;
    size_y_i  = '0;
    m_ready_i = 1'b0;
    for (int i = 0; i < 64; i++) mem_z[i] = '0;
    step();
    step();
    check_idle_outputs("reset");
    rst = 1'b0;
    step();

    run_job(2, 0, 0);
    run_job(2, 1, 0);
    run_job(0, 0, 0);
    run_job(2, 0, 2);
    reset_abort_job();
    run_job(2, 0, 0);
    run_job(31, 0, 0);
    run_job(31, 2, 0);
    for (int j = 0; j < 8; j++) begin
      run_job(int'($urandom_range(0, 31)), int'($urandom_range(0, 2)), 0);
      for (int w = 0; w < int'($urandom_range(0, 2)); w++) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
